// File: rtl/reg_file_p.sv
// CPU register file: general registers, wide bitmap registers and a
// segment engine that streams or clears one bitmap in SEG_W-bit beats.
module reg_file_p #(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int ADDR_W  = 4,
    parameter int BM_W    = 1536,
    parameter int NBM     = 3,
    parameter int BM_AW   = 2,
    parameter int SEG_W   = 16,
    parameter int BYPASS  = 1,
    parameter int DBG_IDX = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic [DATA_W-1:0] rd_data_2,
    input  logic              wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [BM_AW-1:0]  rbm_addr,
    output logic [BM_W-1:0]   rbm_data,
    input  logic              wbm,
    input  logic [BM_AW-1:0]  wbm_addr,
    input  logic [BM_W-1:0]   wbm_data,
    input  logic              seg_start,
    input  logic              seg_mode,
    input  logic [BM_AW-1:0]  seg_bank,
    input  logic              seg_valid,
    input  logic [SEG_W-1:0]  seg_data,
    output logic              seg_ready,
    output logic              bm_busy,
    output logic              bm_done,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NSEG = BM_W / SEG_W;
    localparam int K_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam logic [K_W-1:0]   K_LAST = K_W'(NSEG - 1);
    localparam logic [BM_AW:0]   NBM_L  = (BM_AW + 1)'(NBM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR
    } state_t;

    logic [DATA_W-1:0] regs [NREGS];
    logic [BM_W-1:0]   bm   [NBM];

    state_t           state;
    logic [K_W-1:0]   k;
    logic [BM_AW-1:0] bank;

    logic             start_ok;
    logic             seg_we;
    logic             seg_last;
    logic [SEG_W-1:0] seg_wd;

    assign start_ok = seg_start && ({1'b0, seg_bank} < NBM_L);
    assign seg_we   = (state == S_LOAD && seg_valid) || state == S_CLEAR;
    assign seg_last = (k == K_LAST);
    assign seg_wd   = (state == S_CLEAR) ? '0 : seg_data;

    always_comb begin
        rd_data_1 = regs[rd_addr_1];
        rd_data_2 = regs[rd_addr_2];
        if (BYPASS != 0 && wr && wr_addr == rd_addr_1) rd_data_1 = wr_data;
        if (BYPASS != 0 && wr && wr_addr == rd_addr_2) rd_data_2 = wr_data;
    end

    assign dbg_data = regs[ADDR_W'(DBG_IDX)];

    always_comb begin
        rbm_data = '0;
        for (int b = 0; b < NBM; b++) begin
            if (rbm_addr == BM_AW'(b)) rbm_data = bm[b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Full writes to the bank the engine owns are dropped while it runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBM; b++) bm[b] <= '0;
        end else begin
            for (int b = 0; b < NBM; b++) begin
                if (wbm && wbm_addr == BM_AW'(b) &&
                    !(bm_busy && bank == BM_AW'(b)))
                    bm[b] <= wbm_data;
                if (seg_we && bank == BM_AW'(b))
                    bm[b][int'(k)*SEG_W +: SEG_W] <= seg_wd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            k         <= '0;
            bank      <= '0;
            seg_ready <= 1'b0;
            bm_busy   <= 1'b0;
            bm_done   <= 1'b0;
        end else begin
            bm_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        bank      <= seg_bank;
                        k         <= '0;
                        bm_busy   <= 1'b1;
                        state     <= seg_mode ? S_CLEAR : S_LOAD;
                        seg_ready <= !seg_mode;
                    end
                end
                S_LOAD, S_CLEAR: begin
                    if (seg_we) begin
                        k <= k + 1'b1;
                        if (seg_last) begin
                            state     <= S_IDLE;
                            k         <= '0;
                            seg_ready <= 1'b0;
                            bm_busy   <= 1'b0;
                            bm_done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    seg_ready <= 1'b0;
                    bm_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_p.sv
// Directed bench for reg_file_p: read/write table, segment load/clear,
// bank collisions, stalls and mid-operation reset.
module tb_reg_file_p;

    localparam int BM_W  = 1536;
    localparam int SEG_W = 16;
    localparam int NSEG  = BM_W / SEG_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       rd_addr_1, rd_addr_2, wr_addr;
    logic [15:0]      rd_data_1, rd_data_2, wr_data, dbg_data;
    logic             wr;
    logic [1:0]       rbm_addr, wbm_addr, seg_bank;
    logic [BM_W-1:0]  rbm_data, wbm_data;
    logic             wbm, seg_start, seg_mode, seg_valid;
    logic [15:0]      seg_data;
    logic             seg_ready, bm_busy, bm_done;

    logic [15:0]      nb_rd_1, nb_rd_2, nb_dbg;
    logic [BM_W-1:0]  nb_rbm;
    logic             nb_ready, nb_busy, nb_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_p dut (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_data_1(rd_data_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(rd_data_2),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rbm_addr(rbm_addr), .rbm_data(rbm_data),
        .wbm(wbm), .wbm_addr(wbm_addr), .wbm_data(wbm_data),
        .seg_start(seg_start), .seg_mode(seg_mode), .seg_bank(seg_bank),
        .seg_valid(seg_valid), .seg_data(seg_data),
        .seg_ready(seg_ready), .bm_busy(bm_busy), .bm_done(bm_done),
        .dbg_data(dbg_data)
    );

    reg_file_p #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst),
        .rd_addr_1(rd_addr_1), .rd_data_1(nb_rd_1),
        .rd_addr_2(rd_addr_2), .rd_data_2(nb_rd_2),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rbm_addr(rbm_addr), .rbm_data(nb_rbm),
        .wbm(wbm), .wbm_addr(wbm_addr), .wbm_data(wbm_data),
        .seg_start(seg_start), .seg_mode(seg_mode), .seg_bank(seg_bank),
        .seg_valid(seg_valid), .seg_data(seg_data),
        .seg_ready(nb_ready), .bm_busy(nb_busy), .bm_done(nb_done),
        .dbg_data(nb_dbg)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic [15:0] n1;
        logic [15:0] n2;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_bm(input string name, input logic [BM_W-1:0] act,
                          input logic [BM_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < NSEG; i++) begin
                if (act[i*SEG_W +: SEG_W] !== exp[i*SEG_W +: SEG_W]) begin
                    $display("FAIL %s seg %0d actual %h required %h", name, i,
                             act[i*SEG_W +: SEG_W], exp[i*SEG_W +: SEG_W]);
                    break;
                end
            end
        end
    endtask

    logic [BM_W-1:0] exp_bm, part_bm, p1;
    int n;

    initial begin
        vt[0] = '{1'b1, 4'd5,  16'hBEEF, 4'd5, 4'd5,  16'hBEEF, 16'hBEEF, 16'h0,    16'h0};
        vt[1] = '{1'b0, 4'd0,  16'h0,    4'd5, 4'd5,  16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vt[2] = '{1'b0, 4'd0,  16'h0,    4'd0, 4'd15, 16'h0,    16'h0,    16'h0,    16'h0};
        vt[3] = '{1'b1, 4'd3,  16'h1234, 4'd3, 4'd5,  16'h1234, 16'hBEEF, 16'h0,    16'hBEEF};
        vt[4] = '{1'b0, 4'd0,  16'h0,    4'd3, 4'd3,  16'h1234, 16'h1234, 16'h1234, 16'h1234};
        vt[5] = '{1'b1, 4'd0,  16'hA5A5, 4'd0, 4'd3,  16'hA5A5, 16'h1234, 16'h0,    16'h1234};
        vt[6] = '{1'b1, 4'd12, 16'hCAFE, 4'd4, 4'd12, 16'h0,    16'hCAFE, 16'h0,    16'h0};
        vt[7] = '{1'b0, 4'd0,  16'h0,    4'd0, 4'd12, 16'hA5A5, 16'hCAFE, 16'hA5A5, 16'hCAFE};

        rst = 1'b1; wr = 0; wr_addr = 0; wr_data = 0;
        rd_addr_1 = 0; rd_addr_2 = 0; rbm_addr = 0;
        wbm = 0; wbm_addr = 0; wbm_data = '0;
        seg_start = 0; seg_mode = 0; seg_bank = 0; seg_valid = 0; seg_data = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_rd1", rd_data_1, 0);
        chk("reset_busy", bm_busy, 0);
        chk("reset_ready", seg_ready, 0);
        chk("reset_done", bm_done, 0);
        chk_bm("reset_bm0", rbm_data, '0);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            wr = vt[i].wr; wr_addr = vt[i].wa; wr_data = vt[i].wd;
            rd_addr_1 = vt[i].ra1; rd_addr_2 = vt[i].ra2;
            #1;
            chk($sformatf("vec%0d_rd1", i), rd_data_1, vt[i].e1);
            chk($sformatf("vec%0d_rd2", i), rd_data_2, vt[i].e2);
            chk($sformatf("vec%0d_nb_rd1", i), nb_rd_1, vt[i].n1);
            chk($sformatf("vec%0d_nb_rd2", i), nb_rd_2, vt[i].n2);
            @(negedge clk);
        end
        wr = 0;
        #1 chk("dbg_data", dbg_data, 16'hCAFE);

        // Stream load of bank 1, beat k carries k.
        exp_bm = '0; part_bm = '0;
        for (int k = 0; k < NSEG; k++) exp_bm[k*SEG_W +: SEG_W] = 16'(k);
        for (int k = 0; k < 48; k++) part_bm[k*SEG_W +: SEG_W] = 16'(k);
        @(negedge clk);
        seg_start = 1; seg_mode = 0; seg_bank = 1;
        @(negedge clk);
        seg_start = 0; rbm_addr = 1;
        #1 chk("load_busy", bm_busy, 1);
        chk("load_ready", seg_ready, 1);
        for (int k = 0; k < NSEG; k++) begin
            seg_valid = 1; seg_data = 16'(k);
            @(negedge clk);
            if (k == 47) begin
                #1 chk_bm("load_partial", rbm_data, part_bm);
                chk("load_no_early_done", bm_done, 0);
            end
        end
        seg_valid = 0;
        #1 chk("load_done", bm_done, 1);
        chk("load_idle_busy", bm_busy, 0);
        chk("load_idle_ready", seg_ready, 0);
        chk_bm("load_bank1", rbm_data, exp_bm);
        @(negedge clk);
        #1 chk("load_done_pulse", bm_done, 0);

        // Clear of an all-ones bank 2.
        wbm = 1; wbm_addr = 2; wbm_data = '1;
        @(negedge clk);
        wbm = 0; rbm_addr = 2;
        #1 chk_bm("wbm_bank2", rbm_data, '1);
        seg_start = 1; seg_mode = 1; seg_bank = 2;
        @(negedge clk);
        seg_start = 0;
        #1 chk("clear_ready", seg_ready, 0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            if (!bm_busy) break;
            n++;
            @(negedge clk);
            #1;
        end
        chk("clear_busy_cycles", n, NSEG);
        chk("clear_done", bm_done, 1);
        chk_bm("clear_bank2", rbm_data, '0);
        @(negedge clk);
        #1 chk("clear_done_pulse", bm_done, 0);

        // Load bank 0 with collisions, an ignored start and a stall.
        exp_bm = '0;
        for (int k = 0; k < NSEG; k++) exp_bm[k*SEG_W +: SEG_W] = 16'(16'h100 + k);
        p1 = {NSEG{16'h5A5A}};
        seg_start = 1; seg_mode = 0; seg_bank = 0;
        @(negedge clk);
        seg_start = 0;
        for (int k = 0; k < NSEG; k++) begin
            seg_valid = 1; seg_data = 16'(16'h100 + k);
            wbm = (k == 10 || k == 11);
            wbm_addr = (k == 10) ? 2'd0 : 2'd1;
            wbm_data = (k == 10) ? '1 : p1;
            seg_start = (k == 10); seg_mode = 1; seg_bank = 2;
            @(negedge clk);
            if (k == 11) begin
                wbm = 0; seg_valid = 0; seg_data = 16'hDEAD;
                repeat (5) @(negedge clk);
                #1 chk("stall_busy", bm_busy, 1);
                chk("stall_ready", seg_ready, 1);
            end
        end
        seg_valid = 0; wbm = 0; seg_start = 0;
        #1 chk("coll_done", bm_done, 1);
        rbm_addr = 0;
        #1 chk_bm("coll_bank0", rbm_data, exp_bm);
        rbm_addr = 1;
        #1 chk_bm("coll_bank1", rbm_data, p1);
        rbm_addr = 2;
        #1 chk_bm("coll_bank2", rbm_data, '0);

        // Reset in the middle of a load.
        @(negedge clk);
        seg_start = 1; seg_mode = 0; seg_bank = 1;
        @(negedge clk);
        seg_start = 0;
        for (int k = 0; k < 40; k++) begin
            seg_valid = 1; seg_data = 16'hFFFF;
            @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        rst = 0; seg_valid = 0; rbm_addr = 1; rd_addr_1 = 5;
        #1 chk("rst_busy", bm_busy, 0);
        chk("rst_done", bm_done, 0);
        chk("rst_ready", seg_ready, 0);
        chk_bm("rst_bank1", rbm_data, '0);
        chk("rst_reg5", rd_data_1, 0);
        chk("rst_dbg", dbg_data, 0);
        rbm_addr = 0;
        #1 chk_bm("rst_bank0", rbm_data, '0);
        @(negedge clk);
        #1 chk("rst_no_done", bm_done, 0);

        wbm = 1; wbm_addr = 3; wbm_data = '1;
        @(negedge clk);
        wbm = 0; rbm_addr = 3;
        #1 chk_bm("rbm_addr3", rbm_data, '0);
        for (int b = 0; b < 3; b++) begin
            rbm_addr = 2'(b);
            #1 chk_bm($sformatf("wbm3_bank%0d", b), rbm_data, '0);
        end
        seg_start = 1; seg_mode = 1; seg_bank = 3;
        @(negedge clk);
        seg_start = 0;
        #1 chk("start_bank3_busy", bm_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
